lsu_wbck_lockstep_chk: RTL

- Checker at the consumer end of the redundant-core LSU write-back interface.
- Sits inline on the primary core's LSU write-back path toward commit. Every accepted primary record is captured into a small FIFO.
- Each record is then popped and compared against the matching record from the redundant core's registered write-back outputs, which arrive later and carry no ready.
- Flags mismatch, underflow and timeout, and holds a sticky fault state until software clears it.

---
 rtl/lsu_wbck_lockstep_chk_pkg.sv | 16 +
 rtl/lsu_wbck_lockstep_chk_fifo.sv | 54 +++++
 rtl/lsu_wbck_lockstep_chk.sv | 123 ++++++++++++
 3 files changed

// File: rtl/lsu_wbck_lockstep_chk_pkg.sv
// Shared constants for the LSU write-back lockstep checker.
// Records are opaque REC_W-bit vectors and are compared bit for bit.
package lsu_wbck_lockstep_chk_pkg;

  localparam logic [0:0] StRun   = 1'b0;
  localparam logic [0:0] StFault = 1'b1;

  localparam int unsigned ErrCntW = 8;

  // {wdat, itag, wbck_err, cmt_ld, cmt_st, badaddr, buserr} plus one spare bit
  function automatic int unsigned rec_width(input int unsigned xlen, input int unsigned itag_w,
                                            input int unsigned addr_w);
    return xlen + itag_w + addr_w + 5;
  endfunction

endpackage

// File: rtl/lsu_wbck_lockstep_chk_fifo.sv
// Outstanding-record FIFO: pointers carry a wrap bit, head is read combinationally.
module lsu_wbck_lockstep_chk_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 70
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic [DW-1:0] push_dat_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (pop_i)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Data storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_i && !clr_i) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end

  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/lsu_wbck_lockstep_chk.sv
// Lockstep checker on the LSU write-back path: captures primary records, compares against the
// redundant core. Optional mismatch counter enabled by macro LSU_WBCK_CHK_ERRCNT_EN.
module lsu_wbck_lockstep_chk
  import lsu_wbck_lockstep_chk_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ITAG_W = 1,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned TMO_W  = 6,
  localparam int unsigned REC_W = rec_width(XLEN, ITAG_W, ADDR_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             p_i_valid,
  output logic             p_i_ready,
  input  logic [REC_W-1:0] p_i_rec,
  output logic             p_o_valid,
  input  logic             p_o_ready,
  output logic [REC_W-1:0] p_o_rec,
  input  logic             r_i_valid,
  input  logic [REC_W-1:0] r_i_rec,
  input  logic             chk_clr,
  output logic             chk_fault,
  output logic             chk_mismatch,
  output logic             chk_underflow,
  output logic             chk_timeout,
  output logic             chk_pending
`ifdef LSU_WBCK_CHK_ERRCNT_EN
  ,
  output logic [ErrCntW-1:0] chk_errcnt
`endif
);

  localparam logic [TMO_W-1:0] TmoMax = '1;

  logic             full, empty, push, pop;
  logic [REC_W-1:0] head;
  logic             mis_err, und_err, tmo_err, any_err;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             mis_q, und_q, tmo_q;
  logic [0:0]       state_q, state_d;

  assign p_o_valid = p_i_valid & ~full;
  assign p_i_ready = p_o_ready & ~full;
  assign p_o_rec   = p_i_rec;
  assign push      = p_i_valid & p_i_ready;
  assign pop       = r_i_valid & ~empty;

  lsu_wbck_lockstep_chk_fifo #(
    .DEPTH (DEPTH),
    .DW    (REC_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (chk_clr),
    .push_i     (push),
    .push_dat_i (p_i_rec),
    .pop_i      (pop),
    .head_o     (head),
    .full_o     (full),
    .empty_o    (empty)
  );

  assign mis_err = pop & (head != r_i_rec);
  // A push in the same cycle cannot satisfy a redundant record that arrives while empty.
  assign und_err = r_i_valid & empty;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (chk_clr || pop || empty) tmo_cnt_d = '0;
    else if (tmo_cnt_q != TmoMax) tmo_cnt_d = tmo_cnt_q + {{(TMO_W-1){1'b0}}, 1'b1};
  end

  assign tmo_err = (tmo_cnt_d == TmoMax);
  assign any_err = mis_err | und_err | tmo_err;

  always_comb begin
    state_d = state_q;
    if (chk_clr) state_d = StRun;
    else if (any_err) state_d = StFault;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      state_q   <= StRun;
      mis_q     <= 1'b0;
      und_q     <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      state_q   <= state_d;
      mis_q     <= ~chk_clr & (mis_q | mis_err);
      und_q     <= ~chk_clr & (und_q | und_err);
      tmo_q     <= ~chk_clr & (tmo_q | tmo_err);
    end
  end

  assign chk_fault     = (state_q == StFault);
  assign chk_mismatch  = mis_q;
  assign chk_underflow = und_q;
  assign chk_timeout   = tmo_q;
  assign chk_pending   = ~empty;

`ifdef LSU_WBCK_CHK_ERRCNT_EN
  logic [ErrCntW-1:0] errcnt_q, errcnt_d;

  always_comb begin
    errcnt_d = errcnt_q;
    if (chk_clr) errcnt_d = '0;
    else if (mis_err && (errcnt_q != '1)) errcnt_d = errcnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) errcnt_q <= '0;
    else        errcnt_q <= errcnt_d;
  end

  assign chk_errcnt = errcnt_q;
`endif

endmodule
